// File: rtl/alu_sequencer.sv
// Issue controller for the ALU: arm with an idle function, issue, wait for wout, write back.
// Optional ISSUE timeout with error write-back when ALU_SEQ_TIMEOUT_EN is defined.
`ifndef OPP_WIDTH
  `define OPP_WIDTH 4
`endif
`ifndef REG_WIDTH
  `define REG_WIDTH 8
`endif
`ifndef DEC
  `define DEC 3
`endif

module alu_sequencer #(
  parameter int unsigned            TIMEOUT  = 8,
  parameter logic [`OPP_WIDTH-1:0]  NOP_FUNC = '1
) (
  input  logic                  phi1,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [`OPP_WIDTH-1:0] req_func,
  input  logic [`REG_WIDTH-1:0] req_a,
  input  logic [`REG_WIDTH-1:0] req_b,
  input  logic                  req_carry,
  input  logic [`REG_WIDTH-1:0] req_status,
  input  logic [1:0]            req_dest,
  output logic [`REG_WIDTH-1:0] alu_a,
  output logic [`REG_WIDTH-1:0] alu_b,
  output logic [`OPP_WIDTH-1:0] alu_func,
  output logic                  alu_carry_in,
  output logic                  alu_dec_mode,
  output logic [`REG_WIDTH-1:0] alu_status_in,
  input  logic [`REG_WIDTH-1:0] alu_dout,
  input  logic [`REG_WIDTH-1:0] alu_status_out,
  input  logic                  alu_wout,
  output logic                  wb_valid,
  output logic [`REG_WIDTH-1:0] wb_data,
  output logic [`REG_WIDTH-1:0] wb_status,
  output logic [1:0]            wb_dest,
  output logic                  wb_err,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ARM, ISSUE, WB} state_t;

  // Counter saturates at the timeout count; only cnt>=1 matters when the timeout is disabled.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [7:0]            issue_cnt_q, issue_cnt_d;
  logic [`OPP_WIDTH-1:0] func_q, func_d;
  logic [`REG_WIDTH-1:0] a_q, a_d, b_q, b_d, status_q, status_d;
  logic                  carry_q, carry_d;
  logic [1:0]            dest_q, dest_d;
  logic [`OPP_WIDTH-1:0] alu_func_q, alu_func_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [`REG_WIDTH-1:0] wb_data_q, wb_data_d, wb_status_q, wb_status_d;
  logic [1:0]            wb_dest_q, wb_dest_d;
  logic                  wb_err_q, wb_err_d;
  logic                  busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    func_d      = func_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    status_d    = status_q;
    dest_d      = dest_q;
    wb_data_d   = wb_data_q;
    wb_status_d = wb_status_q;
    wb_dest_d   = wb_dest_q;
    wb_err_d    = wb_err_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            func_d   = req_func;
            a_d      = req_a;
            b_d      = req_b;
            carry_d  = req_carry;
            status_d = req_status;
            dest_d   = req_dest;
            state_d  = ARM;
          end
        end
        ARM: begin
          issue_cnt_d = '0;
          state_d     = ISSUE;
        end
        ISSUE: begin
          if (issue_cnt_q != CNT_LAST) issue_cnt_d = issue_cnt_q + 8'd1;
          if ((issue_cnt_q != '0) && alu_wout) begin
            wb_data_d   = alu_dout;
            wb_status_d = alu_status_out;
            wb_dest_d   = dest_q;
            wb_err_d    = 1'b0;
            state_d     = WB;
          end
`ifdef ALU_SEQ_TIMEOUT_EN
          else if (issue_cnt_q == CNT_LAST) begin
            wb_data_d   = '0;
            wb_status_d = status_q;
            wb_dest_d   = dest_q;
            wb_err_d    = 1'b1;
            state_d     = WB;
          end
`endif
        end
        WB: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    wb_valid_d = (state_d == WB);
    busy_d     = (state_d != IDLE);
    alu_func_d = ((state_d == ISSUE) || (state_d == WB)) ? func_d : NOP_FUNC;
  end

  always_ff @(posedge phi1 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      func_q      <= NOP_FUNC;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      status_q    <= '0;
      dest_q      <= '0;
      alu_func_q  <= NOP_FUNC;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_status_q <= '0;
      wb_dest_q   <= '0;
      wb_err_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      func_q      <= func_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      status_q    <= status_d;
      dest_q      <= dest_d;
      alu_func_q  <= alu_func_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_status_q <= wb_status_d;
      wb_dest_q   <= wb_dest_d;
      wb_err_q    <= wb_err_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready     = (state_q == IDLE) && !reset;
  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign alu_func      = alu_func_q;
  assign alu_carry_in  = carry_q;
  assign alu_dec_mode  = status_q[`DEC];
  assign alu_status_in = status_q;
  assign wb_valid      = wb_valid_q;
  assign wb_data       = wb_data_q;
  assign wb_status     = wb_status_q;
  assign wb_dest       = wb_dest_q;
`ifdef ALU_SEQ_TIMEOUT_EN
  assign wb_err        = wb_err_q;
`else
  assign wb_err        = 1'b0;
`endif
  assign busy          = busy_q;

endmodule
